// File: rtl/alien_fleet.sv
// alien_fleet: alien formation controller (hit test, alive bitmap, march/drop motion, pixel colour).
// Optional macro ALIEN_SPEEDUP_EN shortens the step interval as the fleet thins out.
module alien_fleet #(
   parameter int unsigned COLS         = 8,
   parameter int unsigned ROWS         = 4,
   parameter int unsigned ALIEN_W      = 40,
   parameter int unsigned ALIEN_H      = 20,
   parameter int unsigned H_SPACING    = 60,
   parameter int unsigned V_SPACING    = 40,
   parameter int unsigned X_START      = 40,
   parameter int unsigned Y_START      = 40,
   parameter int unsigned STEP_X       = 4,
   parameter int unsigned STEP_Y       = 20,
   parameter int unsigned MOVE_DIV     = 8,
   parameter int unsigned SCREEN_WIDTH = 640,
   parameter int unsigned LAND_Y       = 410,
   parameter logic [2:0]  ALIEN        = 3'd2,
   parameter logic [2:0]  BACKGROUND   = 3'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [9:0] xLaser,
   input  logic [9:0] yLaser,
   input  logic [9:0] hPos,
   input  logic [9:0] vPos,
   output logic       killingAlien,
   output logic [2:0] colorAlien,
   output logic [5:0] aliensLeft,
   output logic [9:0] fleetX,
   output logic [9:0] fleetY,
   output logic       fleetLanded,
   output logic       fleetCleared
);
   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW = $clog2(MOVE_DIV + 1);

   typedef enum logic [1:0] {MARCH, DROP, LANDED, CLEARED} state_t;

   state_t          state, state_nx;
   logic            dir, dir_nx;
   logic [N-1:0]    alive;
   logic [9:0]      fx_nx, fy_nx;
   logic [DW-1:0]   div_cnt, div_nx, interval;
   logic [10:0]     col_x [COLS];
   logic [10:0]     row_y [ROWS];
   logic [COLS-1:0] col_alive;
   logic [ROWS-1:0] row_alive;
   logic [10:0]     left_edge, right_edge, bottom_edge;
   logic            left_found, hit, hit_valid, pix_on, tick, active;
   logic [IW-1:0]   hit_idx;

   function automatic logic in_box(input logic [9:0] px, input logic [9:0] py,
                                   input logic [10:0] bx, input logic [10:0] by);
      in_box = ({1'b0, px} >= bx) && ({1'b0, px} < bx + 11'(ALIEN_W)) &&
               ({1'b0, py} >= by) && ({1'b0, py} < by + 11'(ALIEN_H));
   endfunction

   always_comb begin
      for (int unsigned c = 0; c < COLS; c++) col_x[c] = {1'b0, fleetX} + 11'(c * H_SPACING);
      for (int unsigned r = 0; r < ROWS; r++) row_y[r] = {1'b0, fleetY} + 11'(r * V_SPACING);
   end

   // Ascending scan order makes the lowest index win the hit priority.
   always_comb begin
      hit       = 1'b0;
      hit_idx   = '0;
      pix_on    = 1'b0;
      col_alive = '0;
      row_alive = '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            if (alive[r*COLS+c]) begin
               col_alive[c] = 1'b1;
               row_alive[r] = 1'b1;
               if (!hit && in_box(xLaser, yLaser, col_x[c], row_y[r])) begin
                  hit     = 1'b1;
                  hit_idx = IW'(r * COLS + c);
               end
               if (in_box(hPos, vPos, col_x[c], row_y[r])) pix_on = 1'b1;
            end
         end
      end
   end

   always_comb begin
      left_edge   = '0;
      right_edge  = '0;
      bottom_edge = '0;
      left_found  = 1'b0;
      for (int unsigned c = 0; c < COLS; c++) begin
         if (col_alive[c]) begin
            if (!left_found) begin
               left_edge  = col_x[c];
               left_found = 1'b1;
            end
            right_edge = col_x[c] + 11'(ALIEN_W);
         end
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (row_alive[r]) bottom_edge = row_y[r] + 11'(ALIEN_H);
      end
   end

   always_comb begin
`ifdef ALIEN_SPEEDUP_EN
      if (32'(aliensLeft) > N / 2)      interval = DW'(MOVE_DIV);
      else if (32'(aliensLeft) > N / 4) interval = DW'(MOVE_DIV / 2);
      else                              interval = DW'(1);
`else
      interval = DW'(MOVE_DIV);
`endif
   end

   assign active    = (state == MARCH) || (state == DROP);
   assign tick      = enable && (div_cnt >= interval - 1'b1);
   assign hit_valid = hit && active && ((xLaser != '0) || (yLaser != '0));

   always_comb begin
      state_nx = state;
      dir_nx   = dir;
      fx_nx    = fleetX;
      fy_nx    = fleetY;
      div_nx   = div_cnt;
      if (active) begin
         if (aliensLeft == '0) begin
            state_nx = CLEARED;
         end else if (bottom_edge >= 11'(LAND_Y)) begin
            state_nx = LANDED;
         end else if (tick) begin
            div_nx = '0;
            if (state == DROP) begin
               fy_nx    = fleetY + 10'(STEP_Y);
               dir_nx   = ~dir;
               state_nx = MARCH;
            end else if (dir) begin
               if (right_edge + 11'(STEP_X) > 11'(SCREEN_WIDTH)) state_nx = DROP;
               else fx_nx = fleetX + 10'(STEP_X);
            end else begin
               if (left_edge < 11'(STEP_X)) state_nx = DROP;
               else fx_nx = fleetX - 10'(STEP_X);
            end
         end else if (enable) begin
            div_nx = div_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= MARCH;
         dir          <= 1'b1;
         alive        <= '1;
         aliensLeft   <= 6'(N);
         fleetX       <= 10'(X_START);
         fleetY       <= 10'(Y_START);
         div_cnt      <= '0;
         killingAlien <= 1'b0;
         colorAlien   <= BACKGROUND;
      end else begin
         state        <= state_nx;
         dir          <= dir_nx;
         fleetX       <= fx_nx;
         fleetY       <= fy_nx;
         div_cnt      <= div_nx;
         killingAlien <= hit_valid;
         colorAlien   <= pix_on ? ALIEN : BACKGROUND;
         if (hit_valid) begin
            alive[hit_idx] <= 1'b0;
            aliensLeft     <= aliensLeft - 6'd1;
         end
      end
   end

   assign fleetLanded  = (state == LANDED);
   assign fleetCleared = (state == CLEARED);
endmodule
